// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch/realign front end.
// Holds the fetch FSM encoding and the C-extension length test.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_ALIGNED   = 2'd0,
    S_BUF       = 2'd1,
    S_ODD_ENTRY = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_compressed(
    input logic [15:0] h
  );
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/instr_fetch_align.sv
// Word fetch plus halfword realignment: emits one 16/32-bit
// instruction and its PC per cycle, including boundary straddlers.
module instr_fetch_align
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_comp_o,
  output logic        valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fa_q, fa_d;
  logic [15:0]  buf_q, buf_d;
  logic [31:0]  tgt;
  logic [15:0]  w_lo, w_hi;
  logic         unused_pc_lsb;

  assign tgt           = {redirect_pc_i[31:1], 1'b0};
  assign unused_pc_lsb = redirect_pc_i[0];
  assign w_lo          = imem_rdata_i[15:0];
  assign w_hi          = imem_rdata_i[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ALIGNED;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      fa_q  <= RESET_PC;
      buf_q <= 16'h0;
    end else begin
      pc_q  <= pc_d;
      fa_q  <= fa_d;
      buf_q <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    buf_d   = buf_q;
    if (redirect_i) begin
      pc_d    = tgt;
      fa_d    = {tgt[31:2], 2'b00};
      buf_d   = 16'h0;
      state_d = tgt[1] ? S_ODD_ENTRY : S_ALIGNED;
    end else if (!stall_i) begin
      case (state_q)
        S_ALIGNED: begin
          fa_d = fa_q + 32'd4;
          if (is_compressed(w_lo)) begin
            buf_d   = w_hi;
            pc_d    = pc_q + 32'd2;
            state_d = S_BUF;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        S_BUF: begin
          // A compressed buffered halfword leaves the fetched word unused
          if (is_compressed(buf_q)) begin
            pc_d    = pc_q + 32'd2;
            state_d = S_ALIGNED;
          end else begin
            buf_d = w_hi;
            pc_d  = pc_q + 32'd4;
            fa_d  = fa_q + 32'd4;
          end
        end
        S_ODD_ENTRY: begin
          buf_d   = w_hi;
          fa_d    = fa_q + 32'd4;
          state_d = S_BUF;
        end
        default: begin
          state_d = S_ALIGNED;
        end
      endcase
    end
  end

  always_comb begin
    instr_o   = NOP_INSTR;
    is_comp_o = 1'b0;
    valid_o   = 1'b0;
    if (reset && !redirect_i) begin
      case (state_q)
        S_ALIGNED: begin
          valid_o = 1'b1;
          if (is_compressed(w_lo)) begin
            instr_o   = {16'h0, w_lo};
            is_comp_o = 1'b1;
          end else begin
            instr_o = imem_rdata_i;
          end
        end
        S_BUF: begin
          valid_o = 1'b1;
          if (is_compressed(buf_q)) begin
            instr_o   = {16'h0, buf_q};
            is_comp_o = 1'b1;
          end else begin
            instr_o = {w_lo, buf_q};
          end
        end
        default: begin
          valid_o = 1'b0;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = fa_q;

endmodule

// File: doc/instr_fetch_align.md
# instr_fetch_align

Fetch-and-realign front end of the 3-stage RV32IC core. It drives the word-aligned instruction-memory address and splits the returned 32-bit words into 16-bit (C-ext) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It presents one instruction plus its PC per cycle to the fetch/decode pipeline register directly downstream. It takes redirects from branch/jump/trap/mret logic and a stall from the hazard unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] must be 00.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold all state and outputs this cycle.
- redirect_i  in  1  control-flow change; has priority over stall_i.
- redirect_pc_i  in  32  redirect target; bit 0 is ignored and treated as 0.
- imem_addr_o  out  32  word-aligned fetch address; bits [1:0] are always 00.
- imem_rdata_i  in  32  instruction word at imem_addr_o, combinational, same cycle.
- instr_o  out  32  instruction. A 16-bit instruction is zero-extended. Equals NOP_INSTR when valid_o=0.
- pc_o  out  32  address of instr_o.
- is_comp_o  out  1  instr_o is a 16-bit instruction.
- valid_o  out  1  instr_o/pc_o are a real, in-order instruction.

## Operation
- State registers: pc_q (next PC to emit), fa_q (word fetch address, drives imem_addr_o), buf_q[15:0] (buffered upper halfword), state_q.
- Compressed test: a halfword h is compressed iff h[1:0] != 2'b11.
- Invariants:
  - S_ALIGNED: fa_q == pc_q.
  - S_BUF: buf_q holds the halfword at pc_q, and fa_q == pc_q + 2.
  - S_ODD_ENTRY: fa_q == pc_q & ~3.
- S_ALIGNED, word W = imem_rdata_i:
  - W[15:0] compressed: emit {16'h0, W[15:0]}, is_comp_o=1. Then buf_q<=W[31:16], pc_q+=2, fa_q+=4, go to S_BUF.
  - Otherwise: emit W, pc_q+=4, fa_q+=4, stay in S_ALIGNED.
- S_BUF:
  - buf_q compressed: emit {16'h0, buf_q}, pc_q+=2, fa_q unchanged, go to S_ALIGNED. The memory word is not consumed.
  - Otherwise: emit {W[15:0], buf_q}, buf_q<=W[31:16], pc_q+=4, fa_q+=4, stay in S_BUF.
- S_ODD_ENTRY: bubble cycle, valid_o=0. buf_q<=W[31:16], fa_q+=4, go to S_BUF.
- Redirect, target T = {redirect_pc_i[31:1], 1'b0}:
  - Current cycle: valid_o=0.
  - Next state: pc_q<=T, fa_q<=T & ~3. If T[1]=0, go to S_ALIGNED; else go to S_ODD_ENTRY.
  - buf_q contents are discarded.
- Stall without redirect: no register changes. Outputs stay constant provided imem_rdata_i stays constant.
- Arithmetic: all PC/address additions are 32-bit modulo 2^32. Wrap from 0xFFFF_FFFC to 0 is legal and is not flagged.

## Timing
- Zero-cycle latency: instr_o, is_comp_o and valid_o are combinational from state_q, buf_q and imem_rdata_i.
- pc_o = pc_q and imem_addr_o = fa_q, both directly from registers.
- Reset asserted (reset=0), effective immediately and asynchronously:
  - state_q=S_ALIGNED, pc_q=fa_q=RESET_PC, buf_q=16'h0.
  - Outputs: valid_o=0, instr_o=NOP_INSTR (32'h0000_0013), is_comp_o=0, pc_o=imem_addr_o=RESET_PC.
- First valid_o=1 is in the first cycle after reset deassertion.
- Reset mid-operation, in any state: buffered halfword and in-flight state are dropped with no partial emission.
- Redirect to an even-word target: 1 bubble (the redirect cycle).
- Redirect to an odd-halfword target: 2 bubbles (redirect cycle plus S_ODD_ENTRY).
- Simultaneous redirect_i and stall_i: the redirect is applied and the stall is ignored.
- A 32-bit instruction straddling a word boundary costs no bubble; it is emitted in the same cycle the second word is read.
- Whenever valid_o=0, is_comp_o=0 and instr_o=NOP_INSTR.

## Structure
- Package fetch_pkg:
  - fetch_state_e enum: S_ALIGNED, S_BUF, S_ODD_ENTRY.
  - NOP_INSTR = 32'h0000_0013.
  - Function is_compressed(logic [15:0]).
- Single module with no sub-module. C-ext expansion is done by the existing decompressor downstream, not here.

## Test plan
- Reset release; mem[0]=32'h00500093, mem[4]=32'h00100113 -> valid_o=1 with pc_o=0 then 4, is_comp_o=0, imem_addr_o 0 then 4 then 8.
- mem[0]=32'h4585_4505 -> (pc 0, 32'h0000_4505, comp), then (pc 2, 32'h0000_4585, comp). imem_addr_o stays 4 across the second cycle, and the next emitted pc is 4.
- mem[0]=32'h0093_4505, mem[4]=32'h4501_0050 -> (pc 0, 32'h0000_4505), (pc 2, 32'h0050_0093, is_comp_o=0), (pc 6, 32'h0000_4501), with no bubbles.
- redirect_i=1 with redirect_pc_i=32'h103 and mem[0x100]=32'h4505_0000:
  - Two valid_o=0 cycles; in the second, imem_addr_o=0x100.
  - Then (pc 0x102, 32'h0000_4505, comp).
- stall_i held 3 cycles while in S_BUF -> outputs and buf_q unchanged, then resume with the correct next instruction. A redirect asserted during the stall takes effect on the next edge.
- Async reset=0 pulse between clock edges while in S_BUF -> outputs immediately show valid_o=0, pc_o=RESET_PC. After release, fetch restarts at RESET_PC with no stale halfword emitted.
